// File: rtl/crosswalk_controller_pkg.sv
// Shared encodings for the pedestrian crossing: car-lane phases (also used by
// intersectionController) and the crossing FSM states.
package crosswalk_controller_pkg;

    typedef enum logic [1:0] {
        PHASE_RED    = 2'b00,
        PHASE_YELLOW = 2'b01,
        PHASE_GREEN  = 2'b10
    } car_phase_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        WALK  = 2'b10,
        FLASH = 2'b11
    } ped_state_e;

endpackage

// File: rtl/crosswalk_controller_second_ticker.sv
// One-second prescaler: pulses tick on the last cycle of each second and reports
// whether the count loaded on this edge falls in the first half of the second.
module second_ticker #(
    parameter int CYCLES_PER_SEC = 5000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick,
    output logic half
);

    localparam int CNT_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES_PER_SEC - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CYCLES_PER_SEC / 2);

    logic [CNT_W-1:0] count_q, count_d;

    // half looks at count_d so a registered lamp driven from it lines up with count_q
    always_comb begin
        tick = (count_q == LAST_CNT);
        if (restart || tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
        half = (count_d < HALF_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/crosswalk_controller.sv
// Pedestrian crossing controller with walk/flash timing and green-phase fault detection.
// Optional macro PED_CHIRP_EN drives chirp with the flash pattern; otherwise chirp is tied low.
module crosswalk_controller
    import crosswalk_controller_pkg::*;
#(
    parameter int CYCLES_PER_SEC = 5000,
    parameter int SEC_W          = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button,
    input  logic [1:0]       car_phase,
    input  logic [SEC_W-1:0] perTime,
    input  logic [SEC_W-1:0] handTime,
    output logic             walk,
    output logic             hand,
    output logic [SEC_W-1:0] countdown,
    output logic             req_pending,
    output logic             ped_hold,
    output logic             fault,
    output logic             chirp
);

    ped_state_e       state_q, state_d;
    logic [SEC_W-1:0] countdown_q, countdown_d;
    logic             walk_q, walk_d;
    logic             hand_q, hand_d;
    logic             req_pending_q, req_pending_d;
    logic             ped_hold_q, ped_hold_d;
    logic             fault_q, fault_d;
    logic             green, ped_active, restart, tick, half;

    function automatic logic [SEC_W-1:0] load_secs(input logic [SEC_W-1:0] secs);
        return (secs == '0) ? SEC_W'(1) : secs;
    endfunction

    second_ticker #(
        .CYCLES_PER_SEC(CYCLES_PER_SEC)
    ) u_ticker (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick),
        .half   (half)
    );

    always_comb begin
        state_d    = state_q;
        green      = (car_phase == PHASE_GREEN);
        ped_active = (state_q == WALK) || (state_q == FLASH);
        case (state_q)
            IDLE:  if (button || req_pending_q) state_d = WAIT;
            WAIT:  if (green) state_d = WALK;
            WALK: begin
                if (!green) state_d = IDLE;
                else if (tick && countdown_q == SEC_W'(1)) state_d = FLASH;
            end
            FLASH: begin
                if (!green) state_d = IDLE;
                else if (tick && countdown_q == SEC_W'(1))
                    state_d = (req_pending_q || button) ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        restart = (state_d != state_q) && ((state_d == WALK) || (state_d == FLASH));

        if (state_d == WALK && state_q != WALK) begin
            countdown_d = load_secs(perTime);
        end else if (state_d == FLASH && state_q != FLASH) begin
            countdown_d = load_secs(handTime);
        end else if (state_d == WALK || state_d == FLASH) begin
            countdown_d = tick ? countdown_q - SEC_W'(1) : countdown_q;
        end else begin
            countdown_d = '0;
        end

        // A press during WALK/FLASH stays latched; only the next walk consumes it
        req_pending_d = (state_d == WALK && state_q != WALK) ? 1'b0 : (req_pending_q | button);
        walk_d        = (state_d == WALK);
        ped_hold_d    = (state_d == WALK) || (state_d == FLASH);
        case (state_d)
            WALK:    hand_d = 1'b0;
            FLASH:   hand_d = half;
            default: hand_d = 1'b1;
        endcase
        fault_d = fault_q | (ped_active && !green);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            countdown_q   <= '0;
            walk_q        <= 1'b0;
            hand_q        <= 1'b1;
            req_pending_q <= 1'b0;
            ped_hold_q    <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            countdown_q   <= countdown_d;
            walk_q        <= walk_d;
            hand_q        <= hand_d;
            req_pending_q <= req_pending_d;
            ped_hold_q    <= ped_hold_d;
            fault_q       <= fault_d;
        end
    end

`ifdef PED_CHIRP_EN
    logic chirp_q, chirp_d;

    always_comb begin
        chirp_d = ((state_d == WALK) || (state_d == FLASH)) && half;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chirp_q <= 1'b0;
        end else begin
            chirp_q <= chirp_d;
        end
    end

    assign chirp = chirp_q;
`else
    assign chirp = 1'b0;
`endif

    assign walk        = walk_q;
    assign hand        = hand_q;
    assign countdown   = countdown_q;
    assign req_pending = req_pending_q;
    assign ped_hold    = ped_hold_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_crosswalk_controller.sv
// Scoreboard bench for crosswalk_controller at CYCLES_PER_SEC=10; expected output
// vectors are queued as stimulus is driven and compared after each clock edge.
module tb_crosswalk_controller;

    localparam int CPS   = 10;
    localparam int SEC_W = 6;
`ifdef PED_CHIRP_EN
    localparam bit CHIRP_ON = 1'b1;
`else
    localparam bit CHIRP_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             button;
    logic [1:0]       car_phase;
    logic [SEC_W-1:0] perTime;
    logic [SEC_W-1:0] handTime;
    logic             walk;
    logic             hand;
    logic [SEC_W-1:0] countdown;
    logic             req_pending;
    logic             ped_hold;
    logic             fault;
    logic             chirp;

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   exp_req;
    bit   exp_fault;

    crosswalk_controller #(
        .CYCLES_PER_SEC(CPS),
        .SEC_W         (SEC_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .button     (button),
        .car_phase  (car_phase),
        .perTime    (perTime),
        .handTime   (handTime),
        .walk       (walk),
        .hand       (hand),
        .countdown  (countdown),
        .req_pending(req_pending),
        .ped_hold   (ped_hold),
        .fault      (fault),
        .chirp      (chirp)
    );

    always #5 clk = ~clk;

    // Vector layout: {walk, hand, countdown[5:0], req_pending, ped_hold, fault, chirp}
    task automatic check_out(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input string tag, input bit w, input bit h, input int cd,
                        input bit hold, input bit ch);
        exp_t e;
        e.tag = tag;
        e.exp = {w, h, 6'(cd), exp_req, hold, exp_fault, ch};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_out(e.tag, {walk, hand, countdown, req_pending, ped_hold, fault, chirp}, e.exp);
    endtask

    task automatic walk_run(input string tag, input int secs, input int first, input int n);
        for (int i = first; i < first + n; i++)
            step(tag, 1'b1, 1'b0, secs - i / CPS, 1'b1, CHIRP_ON && ((i % CPS) < CPS / 2));
    endtask

    task automatic flash_run(input string tag, input int secs, input int first, input int n);
        for (int i = first; i < first + n; i++)
            step(tag, 1'b0, (i % CPS) < CPS / 2, secs - i / CPS, 1'b1,
                 CHIRP_ON && ((i % CPS) < CPS / 2));
    endtask

    task automatic idle_run(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        button    = 1'b0;
        car_phase = 2'b10;
        perTime   = 6'd3;
        handTime  = 6'd2;
        exp_req   = 1'b0;
        exp_fault = 1'b0;
        idle_run("reset", 2);
        reset = 1'b0;
        idle_run("idle", 2);

        // Basic walk cycle on green: 3 s walk, 2 s flash, back to idle
        button = 1'b1; exp_req = 1'b1;
        idle_run("btn_wait", 1);
        button = 1'b0; exp_req = 1'b0;
        walk_run("walk3", 3, 0, 30);
        flash_run("flash2", 2, 0, 20);
        idle_run("idle_after", 3);

        // Request on red waits, then walk once green; mid-walk press and time change
        car_phase = 2'b00; button = 1'b1; exp_req = 1'b1;
        idle_run("wait_btn", 1);
        button = 1'b0;
        idle_run("wait_red", 100);
        car_phase = 2'b10; perTime = 6'd2; handTime = 6'd1; exp_req = 1'b0;
        walk_run("walk2", 2, 0, 12);
        perTime = 6'd9; button = 1'b1; exp_req = 1'b1;
        walk_run("walk_btn", 2, 12, 1);
        button = 1'b0;
        walk_run("walk_latched", 2, 13, 7);
        flash_run("flash1", 1, 0, 10);
        idle_run("rewait", 1);
        exp_req = 1'b0;
        walk_run("walk9", 9, 0, 7);

        // Green lost during walk: abort to idle with sticky fault
        car_phase = 2'b01; exp_fault = 1'b1;
        idle_run("fault", 1);
        car_phase = 2'b11;
        idle_run("fault_hold", 5);
        reset = 1'b1; exp_fault = 1'b0;
        idle_run("fault_rst", 1);
        reset = 1'b0;

        // Zero durations load as one second; press on final flash tick re-requests
        car_phase = 2'b10; perTime = 6'd0; handTime = 6'd0; button = 1'b1; exp_req = 1'b1;
        idle_run("btn0", 1);
        button = 1'b0; exp_req = 1'b0;
        walk_run("walk0", 1, 0, 10);
        flash_run("flash0", 1, 0, 10);
        button = 1'b1; exp_req = 1'b1;
        idle_run("flash_end_btn", 1);
        button = 1'b0; exp_req = 1'b0;
        walk_run("walk0b", 1, 0, 10);
        flash_run("flash0b", 1, 0, 1);
        button = 1'b1; exp_req = 1'b1;
        flash_run("flash_btn", 1, 1, 1);
        button = 1'b0;
        flash_run("flash0c", 1, 2, 2);

        // Reset mid-flash drops everything, including the latched request
        reset = 1'b1; exp_req = 1'b0;
        idle_run("rst_flash", 1);
        reset = 1'b0;
        idle_run("post_rst", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
